mul_share_arb: RTL and testbench
================================

// Module: mul_share_arb
// PURPOSE
//  Parametrised arbiter that shares one pipelined multiplier between NREQ requesters.
//  - Grants at most one operand pair per cycle.
//  - Tracks each in-flight op with a tag through a LAT-deep pipeline.
//  - Returns the product to the originating requester with a one-hot response strobe.
//  Sits in fma_top between the fmad sequencer ports and the shared mul0 instance.
// PARAMETERS
//  NREQ  2   number of requesters (>=1)
//  AW    53  operand A width
//  BW    27  operand B width
//  PW    80  product width (AW+BW)
//  LAT   3   multiplier latency: mul_en cycle to mul_out cycle (>=1)
// PORTS
//  clk       in   1          clock, all state on rising edge
//  reset     in   1          asynchronous, active-low reset
//  req_en    in   NREQ       per-requester operation request
//  req_a     in   NREQ x AW  operand A per requester
//  req_b     in   NREQ x BW  operand B per requester
//  req_gnt   out  NREQ       one-hot grant, same cycle as req_en (combinational)
//  rsp_vld   out  NREQ       one-hot result strobe, registered
//  rsp_out   out  PW         product, broadcast to all requesters
//  mul_en    out  1          issue strobe to the multiplier
//  mul_a     out  AW         operand A to the multiplier
//  mul_b     out  BW         operand B to the multiplier
//  mul_out   in   PW         multiplier product, valid LAT cycles after mul_en
//  busy      out  1          any tag valid in the pipeline
// BEHAVIOUR
//  - Reset (reset=0, async): tag pipe cleared, rr_ptr=0.
//    rsp_vld=0, rsp_out=0, busy=0; req_gnt and mul_en forced 0.
//  - Issue: winner w is picked from req_en; req_gnt[w]=1, mul_en=1.
//    mul_a/mul_b are the winner's operands, or 0 when there is no request.
//  - Losers: req_gnt=0; the requester holds req_en, req_a and req_b stable until granted.
//  - Tag pipe: stage0 <= {mul_en, onehot(w)}; stage k <= stage k-1.
//    The pipe accepts a new op every cycle and never stalls.
//  - Response: in the cycle the last stage holds a valid tag, rsp_out is registered from mul_out
//    and rsp_vld is set to the tag's one-hot in the same register stage.
//    rsp_vld is therefore valid LAT+1 cycles after req_gnt.
//    rsp_out holds its last value when no tag is valid.
//  - busy = OR of the valid bits of all stages.
//  - Same requester re-requesting every cycle: back-to-back grants are legal.
//    Responses return in issue order, one per cycle.
//  - NREQ=1: req_gnt[0]=req_en[0]; no pointer logic.
//  - Reset mid-operation: in-flight tags are discarded and no rsp_vld is produced for them.
//    Late mul_out values are ignored.
// CONFIGURATION
//  MUL_SHARE_RR_EN defined:
//    - Round-robin arbitration: search starts at rr_ptr.
//    - On each grant, rr_ptr <= (w+1) mod NREQ; with no grant, rr_ptr holds.
//  MUL_SHARE_RR_EN undefined:
//    - Fixed priority, lowest index wins; no rr_ptr register.
// STRUCTURE
//  mul_share_pkg:
//    - default width localparams (MS_AW=53, MS_BW=27, MS_PW=80);
//    - typedef ms_tag_t {valid, id onehot} for default NREQ;
//    - function onehot_first(vec, start).
//  Sub-module mul_share_tagpipe (LAT-stage shift register of tags, async active-low reset).
//  The arbiter instantiates it once.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with req_en=2'b11.
//    -> req_gnt=0, mul_en=0, rsp_vld=0, busy=0.
//  2 Single op: req_en=01, a=3, b=5, LAT=3, mul model a*b.
//    -> gnt=01 at t0; rsp_vld=01 with rsp_out=15 at t0+4.
//  3 Contention: req_en=11 held, RR_EN defined.
//    -> grants alternate 01,10,01,10; with RR_EN undefined, gnt=01 every cycle.
//  4 Back-to-back: req0 issues a=1..4 on consecutive cycles.
//    -> rsp_out=b,2b,3b,4b on 4 consecutive cycles, rsp_vld=01 each.
//  5 Reset mid-flight: assert reset 2 cycles after a grant.
//    -> no rsp_vld afterwards; busy=0 immediately.
//  6 NREQ=4, RR: req_en=1010 from rr_ptr=0.
//    -> gnt 0010 then 1000, rr_ptr goes 2 then 0.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared widths, tag type and arbitration helper for mul_share_arb.
// Round-robin arbitration is enabled by defining MUL_SHARE_RR_EN.
package mul_share_pkg;

  localparam int MS_AW     = 53;
  localparam int MS_BW     = 27;
  localparam int MS_PW     = 80;
  localparam int MS_NREQ   = 2;
  localparam int MS_MAXREQ = 32;

  typedef struct packed {
    logic               valid;
    logic [MS_NREQ-1:0] id;
  } ms_tag_t;

  // First set bit of vec at or after start, wrapping within n entries.
  function automatic logic [MS_MAXREQ-1:0] onehot_first(
    input logic [MS_MAXREQ-1:0] vec,
    input int unsigned          start,
    input int unsigned          n
  );
    logic [MS_MAXREQ-1:0] res;
    logic [5:0]           idx;
    logic                 found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MS_MAXREQ; i++) begin
      if (i < n) begin
        idx = 6'(start) + 6'(i);
        if (idx >= 6'(n)) idx = idx - 6'(n);
        if (!found && vec[idx[4:0]]) begin
          res[idx[4:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_share_tagpipe.sv
// LAT-stage tag shift register following ops through the multiplier.
// Never stalls; async active-low reset drops all in-flight tags.
module mul_share_tagpipe
  import mul_share_pkg::*;
#(
  parameter int NREQ = MS_NREQ,
  parameter int LAT  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_vld,
  input  logic [NREQ-1:0] in_id,
  output logic            out_vld,
  output logic [NREQ-1:0] out_id,
  output logic            busy
);

  logic [LAT-1:0]           vld;
  logic [LAT-1:0][NREQ-1:0] id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      id  <= '0;
    end else begin
      vld[0] <= in_vld;
      id[0]  <= in_id;
      for (int k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
        id[k]  <= id[k-1];
      end
    end
  end

  assign out_vld = vld[LAT-1];
  assign out_id  = id[LAT-1];
  assign busy    = |vld;

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier between NREQ requesters.
// Define MUL_SHARE_RR_EN for round-robin, else fixed lowest-index priority.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NREQ = MS_NREQ,
  parameter int AW   = MS_AW,
  parameter int BW   = MS_BW,
  parameter int PW   = MS_PW,
  parameter int LAT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ-1:0][AW-1:0]  req_a,
  input  logic [NREQ-1:0][BW-1:0]  req_b,
  output logic [NREQ-1:0]          req_gnt,
  output logic [NREQ-1:0]          rsp_vld,
  output logic [PW-1:0]            rsp_out,
  output logic                     mul_en,
  output logic [AW-1:0]            mul_a,
  output logic [BW-1:0]            mul_b,
  input  logic [PW-1:0]            mul_out,
  output logic                     busy
);

  logic [NREQ-1:0] gnt_raw;
  logic            tag_vld;
  logic [NREQ-1:0] tag_id;

  generate
    if (NREQ == 1) begin : g_one
      assign gnt_raw = req_en;
    end else begin : g_arb
      localparam int PTRW = $clog2(NREQ);
      logic [PTRW-1:0] start;
`ifdef MUL_SHARE_RR_EN
      logic [PTRW-1:0] rr_ptr;
      logic [PTRW-1:0] w;

      always_comb begin
        w = '0;
        for (int i = 0; i < NREQ; i++)
          if (gnt_raw[i]) w = PTRW'(i);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          rr_ptr <= '0;
        else if (|gnt_raw)
          rr_ptr <= (w == PTRW'(NREQ - 1)) ? '0 : w + PTRW'(1);
      end

      assign start = rr_ptr;
`else
      assign start = '0;
`endif
      assign gnt_raw = NREQ'(onehot_first(
        MS_MAXREQ'(req_en), 32'(start), NREQ));
    end
  endgenerate

  // Grants are suppressed while reset is held.
  assign req_gnt = gnt_raw & {NREQ{reset}};
  assign mul_en  = |req_gnt;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_gnt[i]) begin
        mul_a = req_a[i];
        mul_b = req_b[i];
      end
    end
  end

  mul_share_tagpipe #(
    .NREQ (NREQ),
    .LAT  (LAT)
  ) u_tagpipe (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (mul_en),
    .in_id   (req_gnt),
    .out_vld (tag_vld),
    .out_id  (tag_id),
    .busy    (busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld <= '0;
      rsp_out <= '0;
    end else begin
      rsp_vld <= tag_vld ? tag_id : '0;
      if (tag_vld) rsp_out <= mul_out;
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: vector table, corner sequences
// and randomized traffic against a scoreboard model.
module tb_mul_share_arb;
  import mul_share_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = MS_AW;
  localparam int BW   = MS_BW;
  localparam int PW   = MS_PW;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         req_en;
  logic [NREQ-1:0][AW-1:0] req_a;
  logic [NREQ-1:0][BW-1:0] req_b;
  logic [NREQ-1:0]         req_gnt, rsp_vld;
  logic [PW-1:0]           rsp_out, mul_out;
  logic                    mul_en, busy;
  logic [AW-1:0]           mul_a;
  logic [BW-1:0]           mul_b;

  logic [3:0]              req_en4, req_gnt4, rsp_vld4;
  logic [3:0][AW-1:0]      req_a4;
  logic [3:0][BW-1:0]      req_b4;
  logic [PW-1:0]           rsp_out4, mul_out4;
  logic                    mul_en4, busy4;
  logic [AW-1:0]           mul_a4;
  logic [BW-1:0]           mul_b4;

  mul_share_arb #(
    .NREQ(NREQ), .AW(AW), .BW(BW), .PW(PW), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .req_en(req_en), .req_a(req_a),
    .req_b(req_b), .req_gnt(req_gnt), .rsp_vld(rsp_vld),
    .rsp_out(rsp_out), .mul_en(mul_en), .mul_a(mul_a),
    .mul_b(mul_b), .mul_out(mul_out), .busy(busy)
  );

  mul_share_arb #(
    .NREQ(4), .AW(AW), .BW(BW), .PW(PW), .LAT(LAT)
  ) dut4 (
    .clk(clk), .reset(reset), .req_en(req_en4), .req_a(req_a4),
    .req_b(req_b4), .req_gnt(req_gnt4), .rsp_vld(rsp_vld4),
    .rsp_out(rsp_out4), .mul_en(mul_en4), .mul_a(mul_a4),
    .mul_b(mul_b4), .mul_out(mul_out4), .busy(busy4)
  );

  assign mul_out4 = '0;

  // Behavioural multiplier with LAT cycles of latency, never reset.
  logic [PW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_en ? PW'(mul_a) * PW'(mul_b) : '0;
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_out = mpipe[LAT-1];

  typedef struct {
    int              due;
    logic [NREQ-1:0] id;
    logic [PW-1:0]   prod;
  } exp_t;

  exp_t          q[$];
  int            cyc, tests, fails, rr_m;
  logic [PW-1:0] last_rsp;

  logic [NREQ-1:0] s_gnt, s_rsp_vld;
  logic [PW-1:0]   s_rsp_out;
  logic            s_busy;
  logic [AW-1:0]   s_mul_a;
  logic [BW-1:0]   s_mul_b;
  logic [3:0]      s_gnt4;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int model_winner(logic [NREQ-1:0] en, int start);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (start + i) % NREQ;
      if (en[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_check();
    int              w, st;
    logic [NREQ-1:0] eg;
    logic [AW-1:0]   ea;
    logic [BW-1:0]   eb;
    if (!reset) begin
      chk("rst_gnt", req_gnt, 0);
      chk("rst_mul_en", mul_en, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      rr_m     = 0;
      last_rsp = '0;
      return;
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_vld", rsp_vld, q[0].id);
      chk("rsp_out", rsp_out, q[0].prod);
      last_rsp = q[0].prod;
      void'(q.pop_front());
    end else begin
      chk("rsp_vld_idle", rsp_vld, 0);
      chk("rsp_out_hold", rsp_out, last_rsp);
    end
    chk("busy", busy, q.size() != 0);
`ifdef MUL_SHARE_RR_EN
    st = rr_m;
`else
    st = 0;
`endif
    w  = model_winner(req_en, st);
    eg = (w >= 0) ? NREQ'(1) << w : '0;
    ea = (w >= 0) ? req_a[w] : '0;
    eb = (w >= 0) ? req_b[w] : '0;
    chk("req_gnt", req_gnt, eg);
    chk("mul_en", mul_en, w >= 0);
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    if (w >= 0) begin
      q.push_back('{cyc + LAT + 1, eg, PW'(ea) * PW'(eb)});
      rr_m = (w + 1) % NREQ;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_gnt     = req_gnt;
    s_rsp_vld = rsp_vld;
    s_rsp_out = rsp_out;
    s_busy    = busy;
    s_mul_a   = mul_a;
    s_mul_b   = mul_b;
    s_gnt4    = req_gnt4;
    model_check();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] a0, a1;
    logic [BW-1:0] b0, b1;
    logic [1:0]    gnt;
    logic [AW-1:0] ma;
    logic [BW-1:0] mb;
  } vec_t;

  vec_t vt[5];
  logic [NREQ-1:0] pend;
  logic [3:0]      exp4;

  initial begin
    cyc = 0; tests = 0; fails = 0; rr_m = 0; last_rsp = '0;
    reset = 1'b0;
    req_en = '0; req_a = '0; req_b = '0;
    req_en4 = '0; req_a4 = '0; req_b4 = '0;
    pend = '0;

    // Reset held with both requesting
    req_en = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_gnt", s_gnt, 0);
      chk("t1_rsp_vld", s_rsp_vld, 0);
      chk("t1_busy", s_busy, 0);
    end
    req_en = '0;
    reset  = 1'b1;

    // Single op
    req_en = 2'b01; req_a[0] = 3; req_b[0] = 5;
    tick();
    chk("t2_gnt", s_gnt, 2'b01);
    req_en = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_early_vld", s_rsp_vld, 0);
    end
    tick();
    chk("t2_rsp_vld", s_rsp_vld, 2'b01);
    chk("t2_rsp_out", s_rsp_out, 15);

    // Vector table, each from freshly reset arbiter
    vt[0] = '{2'b00, 53'd7, 53'd9, 27'd2, 27'd4, 2'b00, 53'd0, 27'd0};
    vt[1] = '{2'b01, 53'd11, 53'd13, 27'd3, 27'd6, 2'b01, 53'd11, 27'd3};
    vt[2] = '{2'b10, 53'd11, 53'd13, 27'd3, 27'd6, 2'b10, 53'd13, 27'd6};
    vt[3] = '{2'b11, 53'h1F_FFFF_FFFF_FFFF, 53'd5, 27'h7FF_FFFF, 27'd1,
              2'b01, 53'h1F_FFFF_FFFF_FFFF, 27'h7FF_FFFF};
    vt[4] = '{2'b10, 53'd1, 53'h1F_FFFF_FFFF_FFFF, 27'd1, 27'h7FF_FFFF,
              2'b10, 53'h1F_FFFF_FFFF_FFFF, 27'h7FF_FFFF};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      req_en = vt[i].en;
      req_a[0] = vt[i].a0; req_a[1] = vt[i].a1;
      req_b[0] = vt[i].b0; req_b[1] = vt[i].b1;
      tick();
      chk("vt_gnt", s_gnt, vt[i].gnt);
      chk("vt_mul_a", s_mul_a, vt[i].ma);
      chk("vt_mul_b", s_mul_b, vt[i].mb);
      req_en = '0;
      for (int k = 0; k < LAT + 1; k++) tick();
      chk("vt_prod", s_rsp_out, PW'(vt[i].ma) * PW'(vt[i].mb));
    end

    // Contention with both held
    do_reset();
    req_en = 2'b11;
    req_a[0] = 10; req_b[0] = 2; req_a[1] = 20; req_b[1] = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef MUL_SHARE_RR_EN
      chk("t3_gnt", s_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk("t3_gnt", s_gnt, 2'b01);
`endif
    end
    req_en = '0;
    for (int i = 0; i < LAT + 2; i++) tick();

    // Back-to-back from one requester
    do_reset();
    req_en = 2'b01; req_b[0] = 7;
    for (int i = 1; i <= 4; i++) begin
      req_a[0] = AW'(i);
      tick();
    end
    req_en = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t4_rsp_vld", s_rsp_vld, 2'b01);
      chk("t4_rsp_out", s_rsp_out, 7 * i);
    end

    // Reset mid-flight
    do_reset();
    req_en = 2'b01; req_a[0] = 9; req_b[0] = 9;
    tick();
    req_en = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t5_busy_now", busy, 0);
    chk("t5_vld_now", rsp_vld, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_rsp", s_rsp_vld, 0);
    end

    // Four requesters, 1010 from pointer 0
    do_reset();
    req_en4 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef MUL_SHARE_RR_EN
      exp4 = (i == 1) ? 4'b1000 : 4'b0010;
`else
      exp4 = 4'b0010;
`endif
      chk("t6_gnt4", s_gnt4, exp4);
    end
    req_en4 = '0;

    // Randomized traffic with occasional reset
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          req_a[i] = AW'({$urandom, $urandom});
          req_b[i] = BW'($urandom);
        end
      end
      req_en = pend;
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (s_gnt[i]) pend[i] = 1'b0;
    end
    req_en = '0;
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
